// File: rtl/ddr_arbiter_if.sv
// ----------------------------------------------------------------------------
// ddr_arbiter_if
// Bundles the requester-side and DDR-channel-side signals of ddr_arbiter.
//
// Parameters
//   N_REQ  : number of requesters (2..8)
//   ADDR_W : DDR byte address width
//   LEN_W  : burst length field width (beats-1)
//
// Signals
//   req_valid [N_REQ]        per-requester burst request
//   req_wr    [N_REQ]        1=write burst, 0=read burst
//   req_addr  [N_REQ*ADDR_W] start address, requester i at slice i
//   req_len   [N_REQ*LEN_W]  beats-1, requester i at slice i
//   req_ready [N_REQ]        one-cycle accept pulse to the granted requester
//   cmd_valid / cmd_ready    command handshake to the DDR channel
//   cmd_wr / cmd_addr / cmd_len  latched command fields
//   beat_done                one data beat completed on the DDR channel
//   grant_id                 current owner, used for data-path steering
//   busy                     arbiter not idle
//   err                      sticky protocol error
//
// Modports
//   slave  : the arbiter side
//   master : the environment (requesters + DDR channel)
// ----------------------------------------------------------------------------
interface ddr_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 8
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_wr;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*LEN_W-1:0]  req_len;
  logic [N_REQ-1:0]        req_ready;

  logic                    cmd_valid;
  logic                    cmd_ready;
  logic                    cmd_wr;
  logic [ADDR_W-1:0]       cmd_addr;
  logic [LEN_W-1:0]        cmd_len;
  logic                    beat_done;

  logic [ID_W-1:0]         grant_id;
  logic                    busy;
  logic                    err;

  modport slave (
    input  req_valid, req_wr, req_addr, req_len, cmd_ready, beat_done,
    output req_ready, cmd_valid, cmd_wr, cmd_addr, cmd_len, grant_id, busy, err
  );

  modport master (
    output req_valid, req_wr, req_addr, req_len, cmd_ready, beat_done,
    input  req_ready, cmd_valid, cmd_wr, cmd_addr, cmd_len, grant_id, busy, err
  );
endinterface

// File: rtl/ddr_arbiter.sv
// ----------------------------------------------------------------------------
// ddr_arbiter
// Round-robin arbiter granting one of N_REQ burst requesters access to a
// single DDR command channel. The winner's command is latched, offered on
// cmd_valid until cmd_ready, then the arbiter counts data beats until the
// burst is complete and returns to idle.
//
// Ports
//   core_clk  : sole clock, rising edge
//   sys_rst_n : asynchronous active-low reset; release is synchronised
//               internally before the FSM may leave IDLE
//   bus       : ddr_arbiter_if.slave (requester and DDR channel signals)
//
// Build option
//   DDR_ARB_WDOG_EN : when defined, adds a 10-bit beat watchdog that aborts
//                     a stalled burst (sets err, returns to IDLE and
//                     advances the round-robin pointer).
//
// The interface instance must be built with the same N_REQ/ADDR_W/LEN_W.
// ----------------------------------------------------------------------------
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no owner; picks a round-robin winner when any request is valid
// CMD   | command latched, cmd_valid high, waiting for cmd_ready
// XFER  | command accepted, counting beat_done pulses down to zero
//
module ddr_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic          core_clk,
  input  logic          sys_rst_n,
  ddr_arbiter_if.slave  bus
);

  localparam int            ID_W    = $clog2(N_REQ);
  localparam logic [ID_W:0] N_REQ_X = (ID_W+1)'(N_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    XFER = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [1:0]         r_rst_sync;
  logic               w_run;

  logic [ID_W-1:0]    r_rr_ptr;
  logic [ID_W-1:0]    r_grant_id;
  logic               r_cmd_wr;
  logic [ADDR_W-1:0]  r_cmd_addr;
  logic [LEN_W-1:0]   r_cmd_len;
  logic [LEN_W:0]     r_beat_cnt;
  logic               r_err;

  logic [2*N_REQ-1:0] w_dbl;
  logic [N_REQ-1:0]   w_rot;
  logic               w_found;
  logic [ID_W-1:0]    w_off;
  logic [ID_W:0]      w_sum;
  logic [ID_W-1:0]    w_pick;
  logic [ADDR_W-1:0]  w_pick_addr;
  logic [LEN_W-1:0]   w_pick_len;
  logic [ID_W:0]      w_ptr_sum;
  logic [ID_W-1:0]    w_ptr_nxt;

  logic               w_latch;
  logic               w_accept;
  logic               w_beat_dec;
  logic               w_last;
  logic               w_stray;
  logic               w_wdog_to;
  logic               w_done;
  logic [N_REQ-1:0]   w_ready;
  logic               w_cmd_valid;
  logic               w_busy;

  // Reset release is passed through two flops; the FSM only arbitrates
  // once the release has reached the second stage.
  always_ff @(posedge core_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_run = r_rst_sync[1];

  // Rotate the request vector so that bit 0 is the requester at rr_ptr;
  // the lowest set bit of the rotated vector is the winner's offset.
  assign w_dbl = {bus.req_valid, bus.req_valid} >> r_rr_ptr;
  assign w_rot = w_dbl[N_REQ-1:0];

  always_comb begin
    w_found = 1'b0;
    w_off   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_found = 1'b1;
        w_off   = k[ID_W-1:0];
      end
    end
  end

  always_comb begin
    w_sum = {1'b0, r_rr_ptr} + {1'b0, w_off};
    if (w_sum >= N_REQ_X) begin
      w_sum = w_sum - N_REQ_X;
    end
    w_pick = w_sum[ID_W-1:0];
  end

  assign w_pick_addr = bus.req_addr[w_pick*ADDR_W +: ADDR_W];
  assign w_pick_len  = bus.req_len[w_pick*LEN_W +: LEN_W];

  // Pointer after a burst: the requester just served moves to the back.
  always_comb begin
    w_ptr_sum = {1'b0, r_grant_id} + (ID_W+1)'(1);
    if (w_ptr_sum >= N_REQ_X) begin
      w_ptr_sum = w_ptr_sum - N_REQ_X;
    end
    w_ptr_nxt = w_ptr_sum[ID_W-1:0];
  end

`ifdef DDR_ARB_WDOG_EN
  logic [9:0] r_wdog;

  always_ff @(posedge core_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_wdog <= '0;
    end else if (w_accept || bus.beat_done || (r_state != XFER)) begin
      r_wdog <= '0;
    end else begin
      r_wdog <= r_wdog + 10'd1;
    end
  end

  // Fires on the cycle whose edge would take the watchdog to 1023, so the
  // abort lands exactly 1023 edges after the last beat.
  assign w_wdog_to = (r_state == XFER) && !bus.beat_done && (r_wdog == 10'd1022);
`else
  assign w_wdog_to = 1'b0;
`endif

  always_ff @(posedge core_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_accept    = 1'b0;
    w_beat_dec  = 1'b0;
    w_last      = 1'b0;
    w_stray     = 1'b0;
    w_ready     = '0;
    w_cmd_valid = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      IDLE: begin
        w_busy  = 1'b0;
        w_stray = bus.beat_done;
        if (w_run && w_found) begin
          w_latch     = 1'b1;
          w_state_nxt = CMD;
        end
      end
      CMD: begin
        w_cmd_valid = 1'b1;
        w_stray     = bus.beat_done;
        if (bus.cmd_ready) begin
          w_accept    = 1'b1;
          w_ready     = {{(N_REQ-1){1'b0}}, 1'b1} << r_grant_id;
          w_state_nxt = XFER;
        end
      end
      XFER: begin
        if (bus.beat_done) begin
          w_beat_dec = 1'b1;
          if (r_beat_cnt == (LEN_W+1)'(1)) begin
            w_last      = 1'b1;
            w_state_nxt = IDLE;
          end
        end else if (w_wdog_to) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_done = w_last || w_wdog_to;

  always_ff @(posedge core_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_cmd_wr   <= 1'b0;
      r_cmd_addr <= '0;
      r_cmd_len  <= '0;
      r_beat_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      // Fields are captured once in IDLE and held through CMD and XFER,
      // so a requester dropping its request cannot disturb the command.
      if (w_latch) begin
        r_grant_id <= w_pick;
        r_cmd_wr   <= bus.req_wr[w_pick];
        r_cmd_addr <= w_pick_addr;
        r_cmd_len  <= w_pick_len;
      end

      // Extra counter bit holds len+1 for the maximum len without wrap.
      if (w_accept) begin
        r_beat_cnt <= {1'b0, r_cmd_len} + (LEN_W+1)'(1);
      end else if (w_beat_dec) begin
        r_beat_cnt <= r_beat_cnt - (LEN_W+1)'(1);
      end else if (w_wdog_to) begin
        r_beat_cnt <= '0;
      end

      if (w_done) begin
        r_rr_ptr <= w_ptr_nxt;
      end

      if (w_stray || w_wdog_to) begin
        r_err <= 1'b1;
      end
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.cmd_valid = w_cmd_valid;
  assign bus.cmd_wr    = r_cmd_wr;
  assign bus.cmd_addr  = r_cmd_addr;
  assign bus.cmd_len   = r_cmd_len;
  assign bus.grant_id  = r_grant_id;
  assign bus.busy      = w_busy;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_ddr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ddr_arbiter
// Directed and randomised checks of ddr_arbiter against a request-table
// model: pending requests per requester, a round-robin pointer, and the
// rule that the served requester moves to the back of the order.
// ----------------------------------------------------------------------------
module tb_ddr_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int LW = 8;

  logic core_clk  = 1'b0;
  logic sys_rst_n = 1'b0;

  always #5 core_clk = ~core_clk;

  ddr_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .LEN_W(LW)) bus ();

  ddr_arbiter #(.N_REQ(N), .ADDR_W(AW), .LEN_W(LW)) dut (
    .core_clk  (core_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  int total = 0;
  int bad   = 0;

  bit            pend   [N];
  bit            f_wr   [N];
  logic [AW-1:0] f_addr [N];
  logic [LW-1:0] f_len  [N];
  int            mptr   = 0;
  bit            m_err  = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge core_clk);
    #1;
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i]            = pend[i];
      bus.req_wr[i]               = f_wr[i];
      bus.req_addr[i*AW +: AW]    = f_addr[i];
      bus.req_len[i*LW +: LW]     = f_len[i];
    end
  endtask

  task automatic new_req(input int i);
    pend[i]   = 1'b1;
    f_wr[i]   = 1'($urandom_range(1, 0));
    f_addr[i] = $urandom();
    f_len[i]  = LW'($urandom_range(5, 0));
  endtask

  // First pending requester at or after the pointer, wrapping around.
  function automatic int model_pick();
    for (int k = 0; k < N; k++) begin
      if (pend[(mptr + k) % N]) return (mptr + k) % N;
    end
    return -1;
  endfunction

  task automatic chk_reset_vals(input string t);
    chk({t, "_cmd_valid"}, bus.cmd_valid, 0);
    chk({t, "_cmd_wr"},    bus.cmd_wr,    0);
    chk({t, "_cmd_addr"},  bus.cmd_addr,  0);
    chk({t, "_cmd_len"},   bus.cmd_len,   0);
    chk({t, "_req_ready"}, bus.req_ready, 0);
    chk({t, "_grant_id"},  bus.grant_id,  0);
    chk({t, "_busy"},      bus.busy,      0);
    chk({t, "_err"},       bus.err,       0);
  endtask

  // Called in an IDLE cycle: requests are driven now, command must show next cycle.
  task automatic t_arbitrate(output int w);
    w = model_pick();
    drive_reqs();
    #1;
    chk("pre_busy", bus.busy, 0);
    chk("err_state", bus.err, 64'(m_err));
    step();
    chk("cmd_valid", bus.cmd_valid, 1);
    chk("grant_id",  bus.grant_id,  w);
    chk("cmd_wr",    bus.cmd_wr,    64'(f_wr[w]));
    chk("cmd_addr",  bus.cmd_addr,  f_addr[w]);
    chk("cmd_len",   bus.cmd_len,   f_len[w]);
    chk("cmd_ready0_no_pulse", bus.req_ready, 0);
    chk("cmd_busy",  bus.busy,      1);
  endtask

  task automatic t_accept(input int w, input int bp, input bit drop, input bit hold);
    for (int c = 0; c < bp; c++) begin
      if (drop && c == 0) begin
        pend[w] = 1'b0;
        drive_reqs();
      end
      #1;
      chk("bp_cmd_valid", bus.cmd_valid, 1);
      chk("bp_req_ready", bus.req_ready, 0);
      chk("bp_grant_id",  bus.grant_id,  w);
      chk("bp_cmd_addr",  bus.cmd_addr,  f_addr[w]);
      chk("bp_cmd_len",   bus.cmd_len,   f_len[w]);
      chk("bp_cmd_wr",    bus.cmd_wr,    64'(f_wr[w]));
      step();
    end
    bus.cmd_ready = 1'b1;
    #1;
    chk("accept_pulse", bus.req_ready, 64'(1) << w);
    chk("accept_cmd_valid", bus.cmd_valid, 1);
    step();
    bus.cmd_ready = 1'b0;
    if (!hold) pend[w] = 1'b0;
    drive_reqs();
    #1;
    chk("post_accept_ready", bus.req_ready, 0);
    chk("post_accept_valid", bus.cmd_valid, 0);
    chk("post_accept_busy",  bus.busy,      1);
  endtask

  task automatic t_beats(input int w, input int n, input bit fin, input int maxgap);
    int gap;
    for (int b = 0; b < n; b++) begin
      gap = $urandom_range(maxgap, 0);
      for (int g = 0; g < gap; g++) begin
        bus.beat_done = 1'b0;
        #1;
        chk("xfer_busy",      bus.busy,      1);
        chk("xfer_cmd_valid", bus.cmd_valid, 0);
        chk("xfer_req_ready", bus.req_ready, 0);
        chk("xfer_grant_id",  bus.grant_id,  w);
        step();
      end
      bus.beat_done = 1'b1;
      #1;
      chk("beat_busy", bus.busy, 1);
      step();
    end
    bus.beat_done = 1'b0;
    if (fin) begin
      #1;
      chk("last_beat_idle", bus.busy, 0);
      chk("last_beat_ready", bus.req_ready, 0);
      mptr = (w + 1) % N;
    end
  endtask

  int w;
  int prev_gid;
  int exp_order [5];

  initial begin
    bus.req_valid = '0;
    bus.req_wr    = '0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    bus.cmd_ready = 1'b0;
    bus.beat_done = 1'b0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; f_wr[i] = 1'b0; f_addr[i] = '0; f_len[i] = '0;
    end

    #3;
    chk_reset_vals("rst");
    #9;
    sys_rst_n = 1'b1;
    repeat (3) step();

    // Single request from requester 0: addr 0x1000, 4 beats.
    pend[0] = 1'b1; f_wr[0] = 1'b0; f_addr[0] = 32'h0000_1000; f_len[0] = 8'd3;
    t_arbitrate(w);
    chk("single_gid", bus.grant_id, 0);
    t_accept(w, 0, 1'b0, 1'b0);
    t_beats(w, 4, 1'b1, 2);

    // Backpressure for 10 cycles.
    pend[1] = 1'b1; f_wr[1] = 1'b1; f_addr[1] = 32'h2468_ACE0; f_len[1] = 8'd2;
    t_arbitrate(w);
    t_accept(w, 10, 1'b0, 1'b0);
    t_beats(w, 3, 1'b1, 1);

    // Requester drops its request while the command is still pending.
    pend[2] = 1'b1; f_wr[2] = 1'b0; f_addr[2] = 32'h0BAD_F00D; f_len[2] = 8'd1;
    t_arbitrate(w);
    t_accept(w, 3, 1'b1, 1'b0);
    t_beats(w, 2, 1'b1, 1);

    // Reset in the middle of an 8-beat burst.
    pend[3] = 1'b1; f_wr[3] = 1'b1; f_addr[3] = 32'hFEDC_BA98; f_len[3] = 8'd7;
    t_arbitrate(w);
    chk("mid_gid", bus.grant_id, 3);
    t_accept(w, 0, 1'b0, 1'b0);
    t_beats(w, 2, 1'b0, 1);
    sys_rst_n = 1'b0;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    drive_reqs();
    #1;
    chk_reset_vals("midrst");
    mptr = 0;
    step();
    step();
    pend[1] = 1'b1; f_len[1] = 8'd0;
    drive_reqs();
    sys_rst_n = 1'b1;
    step();
    chk("sync_edge1_idle", bus.busy, 0);
    pend[1] = 1'b0;
    drive_reqs();
    repeat (3) step();

    // Fairness: all requesters continuously pending with single-beat bursts.
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b1; f_len[i] = 8'd0; f_wr[i] = 1'(i); f_addr[i] = AW'(32'h100 * i);
    end
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 2; exp_order[3] = 3; exp_order[4] = 0;
    prev_gid = -1;
    for (int j = 0; j < 5; j++) begin
      t_arbitrate(w);
      chk("fair_order", bus.grant_id, exp_order[j]);
      if (j > 0) chk("fair_no_repeat", 64'(bus.grant_id != prev_gid), 1);
      prev_gid = int'(bus.grant_id);
      t_accept(w, 0, 1'b0, 1'b1);
      t_beats(w, 1, 1'b1, 0);
    end
    for (int i = 0; i < N; i++) pend[i] = 1'b0;

    // Randomised traffic with backpressure and beat gaps.
    for (int t = 0; t < 40; t++) begin
      bit any;
      any = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom_range(1, 0) == 1)) new_req(i);
        any |= pend[i];
      end
      if (!any) new_req(int'($urandom_range(N - 1, 0)));
      t_arbitrate(w);
      t_accept(w, int'($urandom_range(3, 0)), ($urandom_range(7, 0) == 0), 1'b0);
      t_beats(w, int'(f_len[w]) + 1, 1'b1, 2);
    end
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    drive_reqs();

`ifdef DDR_ARB_WDOG_EN
    // Burst of 4 beats stalls after the first beat.
    pend[0] = 1'b1; f_wr[0] = 1'b0; f_addr[0] = 32'h0000_4000; f_len[0] = 8'd3;
    t_arbitrate(w);
    t_accept(w, 0, 1'b0, 1'b0);
    t_beats(w, 1, 1'b0, 0);
    repeat (1022) step();
    chk("wdog_still_busy", bus.busy, 1);
    step();
    chk("wdog_idle", bus.busy, 0);
    chk("wdog_err",  bus.err,  1);
    m_err = 1'b1;
    mptr  = (w + 1) % N;
`endif

    // Stray beat in IDLE sets err and leaves the FSM idle.
    step();
    bus.beat_done = 1'b1;
    step();
    bus.beat_done = 1'b0;
    #1;
    chk("stray_err",  bus.err,  1);
    chk("stray_busy", bus.busy, 0);
    m_err = 1'b1;
    new_req(2);
    t_arbitrate(w);
    t_accept(w, 1, 1'b0, 1'b0);
    t_beats(w, int'(f_len[w]) + 1, 1'b1, 1);
    repeat (3) step();
    chk("stray_err_sticky", bus.err, 1);

    sys_rst_n = 1'b0;
    #1;
    chk_reset_vals("final_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
